// File: rtl/lz77_token_decoder.sv
`default_nettype none
// ============================================================================
// Module   : lz77_token_decoder
// Purpose  : Rebuilds a byte stream from LZ77 (offset, match_len, char_nxt)
//            tokens, one byte per cycle, using a sliding history buffer that
//            every emitted byte refills. A token whose literal is TERM_CHAR
//            ends the stream: its copy bytes are emitted, the terminator
//            itself is not, and `finish` stays high until reset.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            tok_valid  - token present on tok_offset/tok_len/tok_char
//            tok_ready  - decoder can accept a token this cycle
//            tok_offset - back-reference distance, 0 = most recent byte
//            tok_len    - copy length 0..7
//            tok_char   - literal byte following the copy
//            out_valid  - out_char holds a decoded byte
//            out_char   - decoded byte (8'h00 when not valid)
//            finish     - terminator processed (level)
// Revision : 1.0 - initial release
// ============================================================================
module lz77_token_decoder #(
    parameter int         HIST_DEPTH = 9,
    parameter logic [7:0] TERM_CHAR  = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic [3:0] tok_offset,
    input  logic [2:0] tok_len,
    input  logic [7:0] tok_char,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       finish
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_copy = 2'd1;
    localparam logic [1:0] c_st_lit  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0] r_state;
    logic [3:0] r_off;
    logic [2:0] r_cnt;
    logic [7:0] r_lit;
    logic [7:0] r_hist [HIST_DEPTH];

    logic [7:0] w_copy_byte;
    logic       w_lit_is_term;
    logic       w_shift_en;
    logic [7:0] w_shift_byte;

    // Offsets beyond the buffer read as zero. The index is fixed for the
    // whole copy, so an overlapping copy (offset < len) naturally re-reads
    // bytes it has just pushed into the history.
    always_comb begin
        w_copy_byte = 8'h00;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (r_off == 4'(i)) begin
                w_copy_byte = r_hist[i];
            end
        end
    end

    assign w_lit_is_term = (r_lit == TERM_CHAR);
    // Every emitted byte is also the byte shifted into the history.
    assign w_shift_en    = (r_state == c_st_copy) ||
                           ((r_state == c_st_lit) && !w_lit_is_term);
    assign w_shift_byte  = (r_state == c_st_copy) ? w_copy_byte : r_lit;

    assign tok_ready = (r_state == c_st_idle);
    assign out_valid = w_shift_en;
    assign out_char  = w_shift_en ? w_shift_byte : 8'h00;
    assign finish    = (r_state == c_st_done);

    // History shift register: entry 0 takes the emitted byte, the rest
    // move one place older.
    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_hist[gi] <= 8'h00;
                    end else if (w_shift_en) begin
                        r_hist[gi] <= w_shift_byte;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_hist[gi] <= 8'h00;
                    end else if (w_shift_en) begin
                        r_hist[gi] <= r_hist[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_off   <= 4'd0;
            r_cnt   <= 3'd0;
            r_lit   <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (tok_valid) begin
                        r_off   <= tok_offset;
                        r_cnt   <= tok_len;
                        r_lit   <= tok_char;
                        r_state <= (tok_len != 3'd0) ? c_st_copy : c_st_lit;
                    end
                end
                c_st_copy: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= c_st_lit;
                    end
                end
                c_st_lit: begin
                    r_state <= w_lit_is_term ? c_st_done : c_st_idle;
                end
                c_st_done: begin
                    r_state <= c_st_done;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lz77_token_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lz77_token_decoder
// Purpose  : Self-checking bench for lz77_token_decoder: directed token table,
//            terminator / mid-copy reset sequences, and random tokens checked
//            against a byte-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lz77_token_decoder;

    localparam logic [7:0] TERM = 8'h24;

    logic       clk;
    logic       rst;
    logic       tok_valid;
    logic       tok_ready;
    logic [3:0] tok_offset;
    logic [2:0] tok_len;
    logic [7:0] tok_char;
    logic       out_valid;
    logic [7:0] out_char;
    logic       finish;

    int n_vec;
    int n_err;

    // Reference history: the full emitted stream, preceded by 9 zero bytes
    // standing in for cleared history.
    logic [7:0] m_hist [$];

    lz77_token_decoder #(.HIST_DEPTH(9), .TERM_CHAR(8'h24)) dut (
        .clk       (clk),
        .rst       (rst),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_offset(tok_offset),
        .tok_len   (tok_len),
        .tok_char  (tok_char),
        .out_valid (out_valid),
        .out_char  (out_char),
        .finish    (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  off;
        logic [2:0]  len;
        logic [7:0]  ch;
        logic [63:0] exp;   // byte k of the token's output at [8*k +: 8]
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < 9; i++) m_hist.push_back(8'h00);
    endtask

    function automatic logic [63:0] model_token(input int off, input int len, input logic [7:0] ch);
        logic [63:0] e;
        logic [7:0]  b;
        e = '0;
        for (int k = 0; k < len; k++) begin
            b = (off < 9) ? m_hist[m_hist.size() - 1 - off] : 8'h00;
            e[8*k +: 8] = b;
            m_hist.push_back(b);
        end
        if (ch != TERM) begin
            e[8*len +: 8] = ch;
            m_hist.push_back(ch);
        end
        return e;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        tok_valid = 1'b0;
        tick();
        check("rst_ready", 32'(tok_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_char", 32'(out_char), 32'd0);
        model_reset();
    endtask

    // Called in an IDLE cycle. After acceptance the token fields are
    // scrambled; tok_valid stays high if keep_valid is set.
    task automatic run_token(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch,
                             input logic [63:0] exp, input bit keep_valid);
        tok_valid  = 1'b1;
        tok_offset = off;
        tok_len    = len;
        tok_char   = ch;
        check("idle_ready", 32'(tok_ready), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);
        tick();
        tok_valid  = keep_valid;
        tok_offset = 4'($urandom);
        tok_len    = 3'($urandom);
        tok_char   = 8'($urandom);
        for (int k = 0; k < int'(len); k++) begin
            check("copy_valid", 32'(out_valid), 32'd1);
            check("copy_char", 32'(out_char), 32'(exp[8*k +: 8]));
            check("copy_ready", 32'(tok_ready), 32'd0);
            tick();
        end
        if (ch != TERM) begin
            check("lit_valid", 32'(out_valid), 32'd1);
            check("lit_char", 32'(out_char), 32'(exp[8*int'(len) +: 8]));
            check("lit_ready", 32'(tok_ready), 32'd0);
            tick();
        end else begin
            check("term_valid", 32'(out_valid), 32'd0);
            check("term_finish_early", 32'(finish), 32'd0);
            tick();
            check("done_finish", 32'(finish), 32'd1);
            check("done_ready", 32'(tok_ready), 32'd0);
            check("done_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [63:0] e;
        logic [3:0]  r_off;
        logic [2:0]  r_len;
        logic [7:0]  r_ch;

        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b0;
        tok_valid  = 1'b0;
        tok_offset = 4'd0;
        tok_len    = 3'd0;
        tok_char   = 8'h00;

        tbl[0]  = '{4'd0,  3'd0, 8'h31, 64'h31};
        tbl[1]  = '{4'd0,  3'd0, 8'h32, 64'h32};
        tbl[2]  = '{4'd0,  3'd0, 8'h41, 64'h41};
        tbl[3]  = '{4'd0,  3'd3, 8'h42, 64'h42414141};
        tbl[4]  = '{4'd0,  3'd0, 8'h61, 64'h61};
        tbl[5]  = '{4'd0,  3'd0, 8'h62, 64'h62};
        tbl[6]  = '{4'd0,  3'd0, 8'h63, 64'h63};
        tbl[7]  = '{4'd2,  3'd2, 8'h64, 64'h646261};
        tbl[8]  = '{4'd2,  3'd3, 8'h65, 64'h65646261};
        tbl[9]  = '{4'd12, 3'd2, 8'h6d, 64'h6d0000};
        tbl[10] = '{4'd0,  3'd0, 8'h78, 64'h78};
        tbl[11] = '{4'd0,  3'd0, 8'h79, 64'h79};
        tbl[12] = '{4'd1,  3'd2, 8'h24, 64'h7978};

        // Reset, then the directed table with tok_valid held between tokens.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_token(tbl[i].off, tbl[i].len, tbl[i].ch, tbl[i].exp, i < 12);
        end

        // DONE ignores further tokens.
        tok_valid  = 1'b1;
        tok_offset = 4'd0;
        tok_len    = 3'd0;
        tok_char   = 8'h71;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("done_hold_finish", 32'(finish), 32'd1);
            check("done_hold_valid", 32'(out_valid), 32'd0);
            check("done_hold_ready", 32'(tok_ready), 32'd0);
        end

        // Reset during a copy, then a read of unwritten history.
        do_reset();
        tok_valid  = 1'b1;
        tok_offset = 4'd0;
        tok_len    = 3'd7;
        tok_char   = 8'h6b;
        tick();
        tok_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_valid", 32'(out_valid), 32'd1);
            check("abort_char", 32'(out_char), 32'd0);
            if (k == 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check("after_abort_valid", 32'(out_valid), 32'd0);
        check("after_abort_ready", 32'(tok_ready), 32'd1);
        check("after_abort_char", 32'(out_char), 32'd0);
        check("after_abort_finish", 32'(finish), 32'd0);
        model_reset();
        e = model_token(5, 1, 8'h7a);
        run_token(4'd5, 3'd1, 8'h7a, 64'h7a00, 1'b0);

        // Random tokens against the reference model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            r_off = 4'($urandom_range(0, 15));
            r_len = 3'($urandom_range(0, 7));
            r_ch  = 8'($urandom);
            if (r_ch == TERM) r_ch = 8'h25;
            e = model_token(int'(r_off), int'(r_len), r_ch);
            run_token(r_off, r_len, r_ch, e, 1'($urandom_range(0, 1)));
        end
        r_off = 4'($urandom_range(0, 15));
        r_len = 3'($urandom_range(0, 7));
        e = model_token(int'(r_off), int'(r_len), TERM);
        run_token(r_off, r_len, TERM, e, 1'b0);
        tok_valid = 1'b0;
        tick();
        check("final_finish", 32'(finish), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
